// File: rtl/if_stage_hazard.sv
// Instruction-fetch stage: PC, IF/ID register, load-use stall and branch flush.
// Optional performance counters are enabled with `define IF_HAZARD_PERF_CNT_EN.
module if_stage_hazard #(
  parameter logic [63:0] PC_RESET  = 64'h0,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rd,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        id_bubble
`ifdef IF_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  logic [63:0] pc_r, pc_nxt_s;
  logic [63:0] if_id_pc_r, if_id_pc_nxt_s;
  logic [31:0] if_id_instr_r, if_id_instr_nxt_s;
  logic        if_id_valid_r, if_id_valid_nxt_s;
  logic [6:0]  opc_s;
  logic [4:0]  rs1_s, rs2_s;
  logic        uses_rs2_s;
  logic        hazard_s;

  // Decode source registers of the IF/ID instruction and detect load-use hazard
  always_comb begin
    opc_s      = if_id_instr_r[6:0];
    rs1_s      = if_id_instr_r[19:15];
    rs2_s      = if_id_instr_r[24:20];
    uses_rs2_s = 1'b0;
    case (opc_s)
      OPC_OP, OPC_BRANCH, OPC_STORE: uses_rs2_s = 1'b1;
      default:                       uses_rs2_s = 1'b0;
    endcase
    hazard_s = if_id_valid_r & id_ex_memread & (id_ex_rd != 5'd0) &
               ((id_ex_rd == rs1_s) | (uses_rs2_s & (id_ex_rd == rs2_s)));
  end

  // Next PC and IF/ID contents: branch beats stall beats imem wait beats fetch
  always_comb begin
    pc_nxt_s          = pc_r;
    if_id_pc_nxt_s    = if_id_pc_r;
    if_id_instr_nxt_s = if_id_instr_r;
    if_id_valid_nxt_s = if_id_valid_r;
    if (branch_taken) begin
      pc_nxt_s          = branch_target & ~64'h3;
      if_id_pc_nxt_s    = 64'h0;
      if_id_instr_nxt_s = NOP_INSTR;
      if_id_valid_nxt_s = 1'b0;
    end else if (hazard_s) begin
      pc_nxt_s          = pc_r;
      if_id_pc_nxt_s    = if_id_pc_r;
      if_id_instr_nxt_s = if_id_instr_r;
      if_id_valid_nxt_s = if_id_valid_r;
    end else if (!imem_ready) begin
      pc_nxt_s          = pc_r;
      if_id_pc_nxt_s    = pc_r;
      if_id_instr_nxt_s = NOP_INSTR;
      if_id_valid_nxt_s = 1'b0;
    end else begin
      pc_nxt_s          = pc_r + 64'd4;
      if_id_pc_nxt_s    = pc_r;
      if_id_instr_nxt_s = imem_rdata;
      if_id_valid_nxt_s = 1'b1;
    end
  end

  // PC and IF/ID pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r          <= PC_RESET;
      if_id_pc_r    <= 64'h0;
      if_id_instr_r <= NOP_INSTR;
      if_id_valid_r <= 1'b0;
    end else begin
      pc_r          <= pc_nxt_s;
      if_id_pc_r    <= if_id_pc_nxt_s;
      if_id_instr_r <= if_id_instr_nxt_s;
      if_id_valid_r <= if_id_valid_nxt_s;
    end
  end

  assign imem_addr   = pc_r;
  assign if_id_pc    = if_id_pc_r;
  assign if_id_instr = if_id_instr_r;
  assign if_id_valid = if_id_valid_r;
  assign id_bubble   = hazard_s & ~branch_taken;

`ifdef IF_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_r, flush_cnt_r;

  // Saturating stall and flush event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 32'h0;
      flush_cnt_r <= 32'h0;
    end else begin
      if (id_bubble && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (branch_taken && (flush_cnt_r != 32'hFFFF_FFFF)) begin
        flush_cnt_r <= flush_cnt_r + 32'd1;
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;
`endif

endmodule

// File: tb/tb_if_stage_hazard.sv
// Directed, table-driven bench for if_stage_hazard (works with or without
// IF_HAZARD_PERF_CNT_EN defined).
module tb_if_stage_hazard;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rd;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        id_bubble;
`ifdef IF_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  if_stage_hazard dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .branch_taken(branch_taken), .branch_target(branch_target),
    .id_ex_memread(id_ex_memread), .id_ex_rd(id_ex_rd), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid), .id_bubble(id_bubble)
`ifdef IF_HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] NOP  = 32'h0000_0033;
  localparam logic [31:0] I0   = 32'h0000_0013; // addi x0,x0,0
  localparam logic [31:0] ADD  = 32'h0021_82B3; // add x5,x3,x2
  localparam logic [31:0] SW   = 32'h0070_A023; // sw x7,0(x1)
  localparam logic [31:0] LW   = 32'h0070_A203; // lw x4,7(x1): rs2 field = 7
  localparam logic [31:0] X20  = 32'h0010_0093;
  localparam logic [31:0] TGT  = 32'h0020_0113;

  typedef struct {
    logic        bt;
    logic [63:0] tgt;
    logic        mr;
    logic [4:0]  rd;
    logic        rdy;
    logic [31:0] rdata;
    logic [63:0] e_addr;   // before the edge
    logic        e_bub;    // before the edge
    logic [63:0] e_pc;     // after the edge
    logic [31:0] e_instr;
    logic        e_valid;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic bt, input logic [63:0] tgt, input logic mr,
                      input logic [4:0] rd, input logic rdy, input logic [31:0] rdata,
                      input logic [63:0] e_addr, input logic e_bub, input logic [63:0] e_pc,
                      input logic [31:0] e_instr, input logic e_valid);
    vecs[i].bt = bt; vecs[i].tgt = tgt; vecs[i].mr = mr; vecs[i].rd = rd;
    vecs[i].rdy = rdy; vecs[i].rdata = rdata; vecs[i].e_addr = e_addr;
    vecs[i].e_bub = e_bub; vecs[i].e_pc = e_pc; vecs[i].e_instr = e_instr;
    vecs[i].e_valid = e_valid;
  endtask

  initial begin
    //      i  bt   tgt                     mr   rd    rdy  rdata  addr            bub  pc              instr valid
    setv( 0, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b1, I0,  64'h0,          1'b0, 64'h0,          I0,  1'b1);
    setv( 1, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b1, ADD, 64'h4,          1'b0, 64'h4,          ADD, 1'b1);
    setv( 2, 1'b0, 64'h0,                 1'b1, 5'd3, 1'b1, I0,  64'h8,          1'b1, 64'h4,          ADD, 1'b1);
    setv( 3, 1'b0, 64'h0,                 1'b0, 5'd3, 1'b1, I0,  64'h8,          1'b0, 64'h8,          I0,  1'b1);
    setv( 4, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b1, ADD, 64'hC,          1'b0, 64'hC,          ADD, 1'b1);
    setv( 5, 1'b0, 64'h0,                 1'b1, 5'd0, 1'b1, I0,  64'h10,         1'b0, 64'h10,         I0,  1'b1);
    setv( 6, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b1, SW,  64'h14,         1'b0, 64'h14,         SW,  1'b1);
    setv( 7, 1'b0, 64'h0,                 1'b1, 5'd7, 1'b1, I0,  64'h18,         1'b1, 64'h14,         SW,  1'b1);
    setv( 8, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b1, LW,  64'h18,         1'b0, 64'h18,         LW,  1'b1);
    setv( 9, 1'b0, 64'h0,                 1'b1, 5'd7, 1'b1, I0,  64'h1C,         1'b0, 64'h1C,         I0,  1'b1);
    setv(10, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b0, I0,  64'h20,         1'b0, 64'h20,         NOP, 1'b0);
    setv(11, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b0, I0,  64'h20,         1'b0, 64'h20,         NOP, 1'b0);
    setv(12, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b0, I0,  64'h20,         1'b0, 64'h20,         NOP, 1'b0);
    setv(13, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b1, X20, 64'h20,         1'b0, 64'h20,         X20, 1'b1);
    setv(14, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b1, ADD, 64'h24,         1'b0, 64'h24,         ADD, 1'b1);
    setv(15, 1'b1, 64'h103,               1'b1, 5'd3, 1'b1, I0,  64'h28,         1'b0, 64'h0,          NOP, 1'b0);
    setv(16, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b1, TGT, 64'h100,        1'b0, 64'h100,        TGT, 1'b1);
    setv(17, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 5'd0, 1'b1, I0, 64'h104,       1'b0, 64'h0,          NOP, 1'b0);
    setv(18, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b1, I0,  64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, I0, 1'b1);
    setv(19, 1'b0, 64'h0,                 1'b0, 5'd0, 1'b1, ADD, 64'h0,          1'b0, 64'h0,          ADD, 1'b1);

    rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; branch_taken = 1'b0;
    branch_target = 64'h0; id_ex_memread = 1'b0; id_ex_rd = 5'd0;
    #12;
    check("rst_addr",  imem_addr, 64'h0);
    check("rst_pc",    if_id_pc, 64'h0);
    check("rst_instr", {32'h0, if_id_instr}, {32'h0, NOP});
    check("rst_valid", {63'h0, if_id_valid}, 64'h0);
`ifdef IF_HAZARD_PERF_CNT_EN
    check("rst_stall_cnt", {32'h0, stall_cnt}, 64'h0);
    check("rst_flush_cnt", {32'h0, flush_cnt}, 64'h0);
`endif
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      branch_taken = vecs[i].bt; branch_target = vecs[i].tgt;
      id_ex_memread = vecs[i].mr; id_ex_rd = vecs[i].rd;
      imem_ready = vecs[i].rdy; imem_rdata = vecs[i].rdata;
      #1;
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_bubble", i), {63'h0, id_bubble}, {63'h0, vecs[i].e_bub});
      @(posedge clk); #1;
      check($sformatf("v%0d_if_id_pc", i), if_id_pc, vecs[i].e_pc);
      check($sformatf("v%0d_if_id_instr", i), {32'h0, if_id_instr}, {32'h0, vecs[i].e_instr});
      check($sformatf("v%0d_if_id_valid", i), {63'h0, if_id_valid}, {63'h0, vecs[i].e_valid});
    end
    // pc is 4 after vector 19
    check("post_table_addr", imem_addr, 64'h4);
`ifdef IF_HAZARD_PERF_CNT_EN
    check("stall_cnt", {32'h0, stall_cnt}, 64'd2);
    check("flush_cnt", {32'h0, flush_cnt}, 64'd2);
`endif

    // Hazard against ADD held in IF/ID, then async reset in the middle of the stall
    branch_taken = 1'b0; id_ex_memread = 1'b1; id_ex_rd = 5'd2; imem_ready = 1'b1; imem_rdata = I0;
    #1;
    check("stall2_bubble", {63'h0, id_bubble}, 64'h1);
    @(posedge clk); #1;
    check("stall2_hold_addr", imem_addr, 64'h4);
    check("stall2_hold_pc", if_id_pc, 64'h0);
    check("stall2_bubble_persist", {63'h0, id_bubble}, 64'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_addr",  imem_addr, 64'h0);
    check("async_rst_valid", {63'h0, if_id_valid}, 64'h0);
    check("async_rst_instr", {32'h0, if_id_instr}, {32'h0, NOP});
    check("async_rst_bubble", {63'h0, id_bubble}, 64'h0);
`ifdef IF_HAZARD_PERF_CNT_EN
    check("async_rst_stall_cnt", {32'h0, stall_cnt}, 64'h0);
    check("async_rst_flush_cnt", {32'h0, flush_cnt}, 64'h0);
`endif
    id_ex_memread = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("refetch_pc", if_id_pc, 64'h0);
    check("refetch_addr", imem_addr, 64'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
